// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage core (master) and the stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
);
  logic [ADDR_WIDTH-1:0] ID_Rs1_Addr;
  logic [ADDR_WIDTH-1:0] ID_Rs2_Addr;
  logic                  ID_Rs1_Used;
  logic                  ID_Rs2_Used;
  logic                  EX_Mem_r;
  logic                  EX_Reg_w;
  logic [ADDR_WIDTH-1:0] EX_Rd_Addr;
  logic                  EX_Mispredict;
  logic                  MEM_Req;
  logic                  MEM_Ready;
  logic                  PC_Write;
  logic                  IF_ID_Write;
  logic                  IF_ID_Flush;
  logic                  ID_EX_Write;
  logic                  ID_EX_Flush;
  logic                  EX_MEM_Write;
  logic                  MEM_WB_Flush;
  logic                  Mem_Timeout;
  logic [1:0]            Ctrl_State;
  logic [CNT_WIDTH-1:0]  Cnt_LoadUse;
  logic [CNT_WIDTH-1:0]  Cnt_Flush;
  logic [CNT_WIDTH-1:0]  Cnt_MemWait;

  modport master (
    output ID_Rs1_Addr, ID_Rs2_Addr, ID_Rs1_Used, ID_Rs2_Used,
           EX_Mem_r, EX_Reg_w, EX_Rd_Addr, EX_Mispredict, MEM_Req, MEM_Ready,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
           EX_MEM_Write, MEM_WB_Flush, Mem_Timeout, Ctrl_State,
           Cnt_LoadUse, Cnt_Flush, Cnt_MemWait
  );

  modport slave (
    input  ID_Rs1_Addr, ID_Rs2_Addr, ID_Rs1_Used, ID_Rs2_Used,
           EX_Mem_r, EX_Reg_w, EX_Rd_Addr, EX_Mispredict, MEM_Req, MEM_Ready,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
           EX_MEM_Write, MEM_WB_Flush, Mem_Timeout, Ctrl_State,
           Cnt_LoadUse, Cnt_Flush, Cnt_MemWait
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use, mispredict, data-memory wait and timeout fault.
// Optional saturating stall counters are built when STALL_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 255,
  parameter int TO_WIDTH   = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);
  // state    | meaning
  // RUN      | normal issue; resolves mem stall > mispredict > load-use
  // MEM_WAIT | pipeline frozen until data memory completes
  // FAULT    | memory never answered; frozen until reset
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FAULT = 2'd2} state_t;

  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT);

  state_t                state, state_nxt;
  logic [TO_WIDTH-1:0]   wait_cnt, wait_cnt_nxt, wait_cnt_inc;
  logic                  rs1_hit, rs2_hit, load_use, mem_stall, mem_release, wait_limit;

  assign rs1_hit     = hz.ID_Rs1_Used && (hz.ID_Rs1_Addr == hz.EX_Rd_Addr);
  assign rs2_hit     = hz.ID_Rs2_Used && (hz.ID_Rs2_Addr == hz.EX_Rd_Addr);
  assign load_use    = hz.EX_Mem_r && hz.EX_Reg_w && (hz.EX_Rd_Addr != '0) && (rs1_hit || rs2_hit);
  assign mem_stall   = hz.MEM_Req && !hz.MEM_Ready;
  // a withdrawn request releases the freeze just like a completed one
  assign mem_release = !hz.MEM_Req || hz.MEM_Ready;
  assign wait_cnt_inc = wait_cnt + TO_WIDTH'(1);
  assign wait_limit  = (TIMEOUT != 0) && (wait_cnt_inc == TO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_release) begin
          state_nxt = RUN;
        end else begin
          if (wait_cnt != TO_LIMIT) wait_cnt_nxt = wait_cnt_inc;
          if (wait_limit) state_nxt = FAULT;
        end
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    hz.PC_Write     = 1'b1;
    hz.IF_ID_Write  = 1'b1;
    hz.IF_ID_Flush  = 1'b0;
    hz.ID_EX_Write  = 1'b1;
    hz.ID_EX_Flush  = 1'b0;
    hz.EX_MEM_Write = 1'b1;
    hz.MEM_WB_Flush = 1'b0;
    if ((state == FAULT) || (state == MEM_WAIT && !mem_release) || (state == RUN && mem_stall)) begin
      hz.PC_Write     = 1'b0;
      hz.IF_ID_Write  = 1'b0;
      hz.ID_EX_Write  = 1'b0;
      hz.EX_MEM_Write = 1'b0;
      hz.MEM_WB_Flush = 1'b1;
    end else if (state == RUN && hz.EX_Mispredict) begin
      hz.IF_ID_Flush = 1'b1;
      hz.ID_EX_Flush = 1'b1;
    end else if (state == RUN && load_use) begin
      hz.PC_Write    = 1'b0;
      hz.IF_ID_Write = 1'b0;
      hz.ID_EX_Flush = 1'b1;
    end
  end

  assign hz.Mem_Timeout = (state == FAULT);
  assign hz.Ctrl_State  = state;

`ifdef STALL_PERF_CNT_EN
  logic                 ev_lu, ev_fl, ev_fz;
  logic [CNT_WIDTH-1:0] cnt_lu, cnt_fl, cnt_mw;

  assign ev_lu = (state == RUN) && !mem_stall && !hz.EX_Mispredict && load_use;
  assign ev_fl = (state == RUN) && !mem_stall && hz.EX_Mispredict;
  assign ev_fz = (state == RUN && mem_stall) || (state == MEM_WAIT && !mem_release) || (state == FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lu <= '0;
      cnt_fl <= '0;
      cnt_mw <= '0;
    end else begin
      if (ev_lu && cnt_lu != '1) cnt_lu <= cnt_lu + CNT_WIDTH'(1);
      if (ev_fl && cnt_fl != '1) cnt_fl <= cnt_fl + CNT_WIDTH'(1);
      if (ev_fz && cnt_mw != '1) cnt_mw <= cnt_mw + CNT_WIDTH'(1);
    end
  end

  assign hz.Cnt_LoadUse = cnt_lu;
  assign hz.Cnt_Flush   = cnt_fl;
  assign hz.Cnt_MemWait = cnt_mw;
`else
  assign hz.Cnt_LoadUse = '0;
  assign hz.Cnt_Flush   = '0;
  assign hz.Cnt_MemWait = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table plus multi-cycle wait, timeout, reset and saturation sequences.
module tb_pipeline_hazard_ctrl;
  localparam logic [6:0] DEF = 7'b1101010;
  localparam logic [6:0] FRZ = 7'b0000001;
  localparam logic [6:0] MIS = 7'b1111110;
  localparam logic [6:0] LU  = 7'b0001110;

  typedef struct {
    logic [4:0] rs1; logic rs1u; logic [4:0] rs2; logic rs2u;
    logic exmr; logic exrw; logic [4:0] exrd;
    logic mis; logic mreq; logic mrdy;
    logic [6:0] exp_ctl; logic [1:0] exp_st;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  vec_t tv[16];

  pipeline_hazard_ctrl_if #(.ADDR_WIDTH(5), .CNT_WIDTH(4)) hz ();

  pipeline_hazard_ctrl #(.ADDR_WIDTH(5), .TIMEOUT(4), .TO_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] rs1, input logic rs1u, input logic [4:0] rs2,
                              input logic rs2u, input logic exmr, input logic exrw,
                              input logic [4:0] exrd, input logic mis, input logic mreq,
                              input logic mrdy, input logic [6:0] ec, input logic [1:0] es);
    vec_t v;
    v.rs1 = rs1; v.rs1u = rs1u; v.rs2 = rs2; v.rs2u = rs2u;
    v.exmr = exmr; v.exrw = exrw; v.exrd = exrd;
    v.mis = mis; v.mreq = mreq; v.mrdy = mrdy;
    v.exp_ctl = ec; v.exp_st = es;
    return v;
  endfunction

  function automatic int exp_cnt(input int v);
`ifdef STALL_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic logic [6:0] ctl();
    return {hz.PC_Write, hz.IF_ID_Write, hz.IF_ID_Flush, hz.ID_EX_Write,
            hz.ID_EX_Flush, hz.EX_MEM_Write, hz.MEM_WB_Flush};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    hz.ID_Rs1_Addr = v.rs1; hz.ID_Rs1_Used = v.rs1u;
    hz.ID_Rs2_Addr = v.rs2; hz.ID_Rs2_Used = v.rs2u;
    hz.EX_Mem_r = v.exmr; hz.EX_Reg_w = v.exrw; hz.EX_Rd_Addr = v.exrd;
    hz.EX_Mispredict = v.mis; hz.MEM_Req = v.mreq; hz.MEM_Ready = v.mrdy;
  endtask

  task automatic set_idle();
    apply(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, DEF, 2'd0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic chk_counters(input string tag, input int lu, input int fl, input int mw);
    chk({tag, "_cnt_loaduse"}, 32'(hz.Cnt_LoadUse), 32'(exp_cnt(lu)));
    chk({tag, "_cnt_flush"},   32'(hz.Cnt_Flush),   32'(exp_cnt(fl)));
    chk({tag, "_cnt_memwait"}, 32'(hz.Cnt_MemWait), 32'(exp_cnt(mw)));
  endtask

  initial begin
    tv[0]  = mk(5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, DEF, 2'd0);
    tv[1]  = mk(5'd5, 1, 5'd1, 1, 1, 1, 5'd5, 0, 0, 0, LU,  2'd0);
    tv[2]  = mk(5'd5, 1, 5'd1, 1, 0, 1, 5'd5, 0, 0, 0, DEF, 2'd0);
    tv[3]  = mk(5'd0, 1, 5'd0, 0, 1, 1, 5'd0, 0, 0, 0, DEF, 2'd0);
    tv[4]  = mk(5'd3, 1, 5'd7, 0, 1, 1, 5'd7, 0, 0, 0, DEF, 2'd0);
    tv[5]  = mk(5'd3, 1, 5'd7, 1, 1, 1, 5'd7, 0, 0, 0, LU,  2'd0);
    tv[6]  = mk(5'd3, 1, 5'd7, 1, 1, 0, 5'd7, 0, 0, 0, DEF, 2'd0);
    tv[7]  = mk(5'd5, 1, 5'd1, 1, 1, 1, 5'd5, 1, 0, 0, MIS, 2'd0);
    tv[8]  = mk(5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0, FRZ, 2'd0);
    tv[9]  = mk(5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0, FRZ, 2'd1);
    tv[10] = mk(5'd5, 1, 5'd1, 1, 1, 1, 5'd5, 1, 1, 1, DEF, 2'd1);
    tv[11] = mk(5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, MIS, 2'd0);
    tv[12] = mk(5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, DEF, 2'd0);
    tv[13] = mk(5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, FRZ, 2'd0);
    tv[14] = mk(5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, DEF, 2'd1);
    tv[15] = mk(5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, DEF, 2'd0);

    // reset state
    set_idle();
    #2;
    chk("reset_state", 32'(hz.Ctrl_State), 32'd0);
    chk("reset_timeout", 32'(hz.Mem_Timeout), 32'd0);
    chk("reset_ctl", 32'(ctl()), 32'(DEF));
    chk_counters("reset", 0, 0, 0);
    #1;
    rst_n = 1'b1;

    // vector table trace
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      apply(tv[i]);
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(tv[i].exp_ctl));
      chk($sformatf("vec%0d_state", i), 32'(hz.Ctrl_State), 32'(tv[i].exp_st));
    end
    @(negedge clk);
    set_idle();
    #1;
    chk_counters("table", 2, 2, 3);

    // three not-ready cycles with a mispredict held, then release
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      hz.EX_Mispredict = 1'b1; hz.MEM_Req = 1'b1; hz.MEM_Ready = 1'b0;
      #1;
      chk($sformatf("wait%0d_ctl", k), 32'(ctl()), 32'(FRZ));
      chk($sformatf("wait%0d_state", k), 32'(hz.Ctrl_State), (k == 0) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    hz.MEM_Ready = 1'b1;
    #1;
    chk("release_ctl", 32'(ctl()), 32'(DEF));
    chk("release_state", 32'(hz.Ctrl_State), 32'd1);
    @(negedge clk);
    hz.MEM_Req = 1'b0; hz.MEM_Ready = 1'b0;
    #1;
    chk("post_release_ctl", 32'(ctl()), 32'(MIS));
    chk("post_release_state", 32'(hz.Ctrl_State), 32'd0);
    @(negedge clk);
    set_idle();
    #1;
    chk_counters("memwait", 0, 1, 3);

    // asynchronous reset in the middle of MEM_WAIT
    do_reset();
    @(negedge clk);
    hz.MEM_Req = 1'b1; hz.MEM_Ready = 1'b0;
    @(negedge clk);
    #1;
    chk("midwait_state", 32'(hz.Ctrl_State), 32'd1);
    set_idle();
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_state", 32'(hz.Ctrl_State), 32'd0);
    chk("midwait_rst_timeout", 32'(hz.Mem_Timeout), 32'd0);
    chk_counters("midwait_rst", 0, 0, 0);
    #1;
    rst_n = 1'b1;

    // timeout: RUN entry + 4 wait cycles, then FAULT forever
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      hz.MEM_Req = 1'b1; hz.MEM_Ready = 1'b0;
      #1;
      chk($sformatf("to%0d_state", k), 32'(hz.Ctrl_State), (k == 0) ? 32'd0 : 32'd1);
      chk($sformatf("to%0d_timeout", k), 32'(hz.Mem_Timeout), 32'd0);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      hz.MEM_Req = k[0]; hz.MEM_Ready = 1'b1; hz.EX_Mispredict = k[1];
      #1;
      chk($sformatf("fault%0d_state", k), 32'(hz.Ctrl_State), 32'd2);
      chk($sformatf("fault%0d_ctl", k), 32'(ctl()), 32'(FRZ));
      chk($sformatf("fault%0d_timeout", k), 32'(hz.Mem_Timeout), 32'd1);
    end
    @(negedge clk);
    #1;
    chk("fault_cnt_memwait_sat", 32'(hz.Cnt_MemWait), 32'(exp_cnt(15)));
    set_idle();
    rst_n = 1'b0;
    #1;
    chk("fault_rst_state", 32'(hz.Ctrl_State), 32'd0);
    chk("fault_rst_timeout", 32'(hz.Mem_Timeout), 32'd0);
    chk("fault_rst_ctl", 32'(ctl()), 32'(DEF));
    chk_counters("fault_rst", 0, 0, 0);
    #1;
    rst_n = 1'b1;

    // 20 separate load-use hazards saturate a 4-bit counter
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      apply(tv[1]);
      #1;
      chk($sformatf("sat%0d_ctl", k), 32'(ctl()), 32'(LU));
      @(negedge clk);
      set_idle();
      #1;
      chk($sformatf("sat%0d_idle_ctl", k), 32'(ctl()), 32'(DEF));
    end
    @(negedge clk);
    #1;
    chk_counters("sat", 15, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
